// File: rtl/result_aggregator_pkg.sv
// Shared datapath types for the PIM result path: element width, chunk geometry
// and the unpacked chunk type exchanged between the aggregator and its adder.
package result_aggregator_pkg;

  localparam int WIDTH       = 16;
  localparam int CHUNK_SIZE  = 2;
  localparam int CHUNK_ELEMS = CHUNK_SIZE ** 2;

  typedef logic [WIDTH-1:0] chunk_t [CHUNK_ELEMS];

  // Unsigned modulo-2^WIDTH element add; the carry out is intentionally dropped.
  function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/result_aggregator_adder.sv
// Combinational element-wise chunk adder; load selects the addend alone so the
// first chunk of a tile never reads the stale accumulator.
module chunk_adder
  import result_aggregator_pkg::*;
(
  input  logic   load,
  input  chunk_t acc,
  input  chunk_t addend,
  output chunk_t sum
);

  // Per-element load-or-accumulate.
  always_comb begin
    for (int e = 0; e < CHUNK_ELEMS; e++) begin
      if (load) begin
        sum[e] = addend[e];
      end else begin
        sum[e] = add_mod(acc[e], addend[e]);
      end
    end
  end

endmodule

// File: rtl/result_aggregator.sv
// Sums NUM_K_CHUNKS consecutive partial-product chunks into one output tile and
// hands it to writeback over valid/ready; accumulator and output are double-buffered.
module result_aggregator
  import result_aggregator_pkg::*;
#(
  parameter  int NUM_K_CHUNKS = 4,
  parameter  int NUM_TILES    = 16,
  localparam int K_W          = (NUM_K_CHUNKS > 1) ? $clog2(NUM_K_CHUNKS) : 1,
  localparam int IDX_W        = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH*CHUNK_ELEMS-1:0] in_tile,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH*CHUNK_ELEMS-1:0] out_tile,
  output logic [IDX_W-1:0]             out_tile_idx
);

  localparam logic [K_W-1:0]   K_LAST    = K_W'(NUM_K_CHUNKS - 1);
  localparam logic [IDX_W-1:0] TILE_LAST = IDX_W'(NUM_TILES - 1);

  chunk_t                         in_chunk_s;
  chunk_t                         acc_r;
  chunk_t                         sum_s;
  logic [K_W-1:0]                 k_cnt_r;
  logic [IDX_W-1:0]               tile_cnt_r;
  logic [IDX_W-1:0]               out_idx_r;
  logic                           out_valid_r;
  logic [WIDTH*CHUNK_ELEMS-1:0]   out_tile_r;
  logic                           last_k_s;
  logic                           in_ready_s;
  logic                           accept_s;
  logic                           complete_s;
  logic                           pop_s;

  // Unflatten the row-major input bus into chunk elements.
  always_comb begin
    for (int e = 0; e < CHUNK_ELEMS; e++) begin
      in_chunk_s[e] = in_tile[e*WIDTH +: WIDTH];
    end
  end

  chunk_adder u_adder (
    .load   (k_cnt_r == {K_W{1'b0}}),
    .acc    (acc_r),
    .addend (in_chunk_s),
    .sum    (sum_s)
  );

  // Handshake qualifiers; only a completing beat can be held off by a full output buffer.
  always_comb begin
    last_k_s   = (k_cnt_r == K_LAST);
    in_ready_s = !(last_k_s && out_valid_r && !out_ready);
    accept_s   = in_valid && in_ready_s && !flush;
    complete_s = accept_s && last_k_s;
    pop_s      = out_valid_r && out_ready;
  end

  // k-chunk and tile sequence counters; flush restarts the tile but keeps its number.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k_cnt_r    <= {K_W{1'b0}};
      tile_cnt_r <= {IDX_W{1'b0}};
    end else if (flush) begin
      k_cnt_r    <= {K_W{1'b0}};
    end else if (accept_s) begin
      if (last_k_s) begin
        k_cnt_r <= {K_W{1'b0}};
        if (tile_cnt_r == TILE_LAST) begin
          tile_cnt_r <= {IDX_W{1'b0}};
        end else begin
          tile_cnt_r <= tile_cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end
      end else begin
        k_cnt_r <= k_cnt_r + {{(K_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Running accumulator for the tile in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int e = 0; e < CHUNK_ELEMS; e++) acc_r[e] <= {WIDTH{1'b0}};
    end else if (flush) begin
      for (int e = 0; e < CHUNK_ELEMS; e++) acc_r[e] <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      acc_r <= sum_s;
    end
  end

  // Output buffer: a completing beat overwrites it even while it is being popped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_r <= 1'b0;
      out_idx_r   <= {IDX_W{1'b0}};
      out_tile_r  <= {(WIDTH*CHUNK_ELEMS){1'b0}};
    end else if (complete_s) begin
      out_valid_r <= 1'b1;
      out_idx_r   <= tile_cnt_r;
      for (int e = 0; e < CHUNK_ELEMS; e++) out_tile_r[e*WIDTH +: WIDTH] <= sum_s[e];
    end else if (pop_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready     = in_ready_s;
  assign out_valid    = out_valid_r;
  assign out_tile     = out_tile_r;
  assign out_tile_idx = out_idx_r;

endmodule

// File: tb/tb_result_aggregator.sv
// Randomised and directed bench for result_aggregator (K=3, 4 tiles) checked
// against a transaction-level model of the summing and output-buffer rules.
module tb_result_aggregator;

  localparam int K = 3;
  localparam int T = 4;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_tile;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_tile;
  logic [1:0]  out_tile_idx;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // reference model state
  int m_cnt;
  int m_sum [4];
  int m_out [4];
  bit m_ov;
  int m_idx;
  int m_tile;

  result_aggregator #(.NUM_K_CHUNKS(K), .NUM_TILES(T)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tile      (in_tile),
    .flush        (flush),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tile     (out_tile),
    .out_tile_idx (out_tile_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [63:0] model_tile();
    logic [63:0] v;
    for (int e = 0; e < 4; e++) v[e*16 +: 16] = 16'(m_out[e]);
    return v;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_ov = 1'b0; m_idx = 0; m_tile = 0;
    for (int e = 0; e < 4; e++) begin m_sum[e] = 0; m_out[e] = 0; end
  endtask

  // Drive one cycle's inputs, check outputs against the model, advance past one edge.
  task automatic step(input bit iv, input logic [63:0] it, input bit ordy, input bit fl,
                      output bit rdy_seen);
    bit exp_rdy, acc, pop;
    in_valid = iv; in_tile = it; out_ready = ordy; flush = fl;
    #1;
    exp_rdy = !(m_cnt == K-1 && m_ov && !ordy);
    rdy_seen = in_ready;
    check_value("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check_value("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
    if (m_ov) begin
      check_value("out_tile", out_tile, model_tile());
      check_value("out_idx", {62'd0, out_tile_idx}, 64'(m_idx));
    end
    acc = iv && exp_rdy && !fl;
    pop = m_ov && ordy;
    if (pop) m_ov = 1'b0;
    if (fl) begin
      m_cnt = 0;
      for (int e = 0; e < 4; e++) m_sum[e] = 0;
    end else if (acc) begin
      for (int e = 0; e < 4; e++)
        m_sum[e] = ((m_cnt == 0) ? 0 : m_sum[e]) + int'(it[e*16 +: 16]);
      for (int e = 0; e < 4; e++) m_sum[e] = m_sum[e] & 32'hFFFF;
      if (m_cnt == K-1) begin
        for (int e = 0; e < 4; e++) m_out[e] = m_sum[e];
        m_idx  = m_tile;
        m_tile = (m_tile + 1) % T;
        m_ov   = 1'b1;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    in_valid = 1'b0; in_tile = 64'd0; out_ready = 1'b0; flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_value("rst_valid", {63'd0, out_valid}, 64'd0);
    check_value("rst_tile", out_tile, 64'd0);
    check_value("rst_idx", {62'd0, out_tile_idx}, 64'd0);
    rst_n = 1'b1;
    #1;
    check_value("rst_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
  endtask

  bit r;

  initial begin
    rst_n = 1'b0;
    do_reset();

    // basic sum
    step(1'b1, mk(1, 2, 3, 4), 1'b1, 1'b0, r);
    step(1'b1, mk(10, 20, 30, 40), 1'b1, 1'b0, r);
    step(1'b1, mk(100, 200, 300, 400), 1'b1, 1'b0, r);
    check_value("basic_valid", {63'd0, out_valid}, 64'd1);
    check_value("basic_tile", out_tile, mk(111, 222, 333, 444));
    check_value("basic_idx", {62'd0, out_tile_idx}, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, r);
    check_value("basic_pulse", {63'd0, out_valid}, 64'd0);

    // modulo wrap
    do_reset();
    repeat (3) step(1'b1, mk(16'h8000, 16'hFFFF, 1, 0), 1'b1, 1'b0, r);
    check_value("wrap_tile", out_tile, mk(16'h8000, 16'hFFFD, 3, 0));
    step(1'b0, 64'd0, 1'b1, 1'b0, r);

    // backpressure on the completing beat
    do_reset();
    repeat (3) step(1'b1, mk(7, 7, 7, 7), 1'b0, 1'b0, r);
    step(1'b1, mk(1, 1, 1, 1), 1'b0, 1'b0, r);
    check_value("bp_rdy1", {63'd0, r}, 64'd1);
    step(1'b1, mk(1, 1, 1, 1), 1'b0, 1'b0, r);
    check_value("bp_rdy2", {63'd0, r}, 64'd1);
    step(1'b1, mk(1, 1, 1, 1), 1'b0, 1'b0, r);
    check_value("bp_stall", {63'd0, r}, 64'd0);
    check_value("bp_hold", out_tile, mk(21, 21, 21, 21));
    step(1'b1, mk(1, 1, 1, 1), 1'b1, 1'b0, r);
    check_value("bp_rdy3", {63'd0, r}, 64'd1);
    check_value("bp_valid", {63'd0, out_valid}, 64'd1);
    check_value("bp_tile", out_tile, mk(3, 3, 3, 3));
    check_value("bp_idx", {62'd0, out_tile_idx}, 64'd1);
    step(1'b0, 64'd0, 1'b1, 1'b0, r);

    // flush discards the partial tile
    do_reset();
    repeat (2) step(1'b1, mk(5, 5, 5, 5), 1'b1, 1'b0, r);
    step(1'b1, mk(9, 9, 9, 9), 1'b1, 1'b1, r);
    repeat (3) step(1'b1, mk(1, 2, 3, 4), 1'b1, 1'b0, r);
    check_value("flush_tile", out_tile, mk(3, 6, 9, 12));
    check_value("flush_idx", {62'd0, out_tile_idx}, 64'd0);
    step(1'b0, 64'd0, 1'b1, 1'b0, r);

    // tile index wrap
    do_reset();
    for (int t = 0; t < 5; t++) begin
      repeat (3) step(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, r);
      check_value("idx_wrap", {62'd0, out_tile_idx}, 64'(t % T));
    end
    step(1'b0, 64'd0, 1'b1, 1'b0, r);

    // asynchronous reset mid-tile with a full output buffer
    do_reset();
    repeat (3) step(1'b1, mk(2, 2, 2, 2), 1'b0, 1'b0, r);
    repeat (2) step(1'b1, mk(4, 4, 4, 4), 1'b0, 1'b0, r);
    #2;
    rst_n = 1'b0;
    #1;
    check_value("arst_valid", {63'd0, out_valid}, 64'd0);
    check_value("arst_tile", out_tile, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) step(1'b1, mk(6, 7, 8, 9), 1'b1, 1'b0, r);
    check_value("arst_sum", out_tile, mk(18, 21, 24, 27));
    check_value("arst_idx", {62'd0, out_tile_idx}, 64'd0);

    // randomised traffic
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(0, 3) != 0), {$urandom, $urandom},
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 19) == 0), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/result_aggregator.md
Name: result_aggregator

Overview:
- Sits directly downstream of the per-chunk PIM multiply units.
- Consumes the flattened CHUNK_SIZE x CHUNK_SIZE partial-product chunks they produce and sums NUM_K_CHUNKS consecutive chunks (the k-dimension of a blocked matmul) into one output tile.
- Presents each finished tile to the writeback side through a valid/ready handshake.
- Double-buffered (accumulator + output register), so accumulation of the next tile overlaps the drain of the current one.

Parameters:
- NUM_K_CHUNKS, 4: partial-product chunks summed per output tile (>=1).
- NUM_TILES, 16: output tiles per full matrix; the tile index wraps at this value (>=1).
- WIDTH, CHUNK_SIZE: taken from the shared package, not redeclared.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- in_valid  in  1  in_tile holds a valid partial-product chunk (driven from PIM result_valid).
- in_ready  out  1  aggregator accepts in_tile this cycle.
- in_tile  in  WIDTH x CHUNK_SIZE**2  flattened row-major chunk, element idx = i*CHUNK_SIZE+j.
- flush  in  1  synchronous discard of the partially accumulated tile.
- out_valid  out  1  out_tile/out_tile_idx hold a completed tile.
- out_ready  in  1  consumer accepts the completed tile.
- out_tile  out  WIDTH x CHUNK_SIZE**2  completed tile, same layout as in_tile.
- out_tile_idx  out  $clog2(NUM_TILES) (min 1)  sequence number of the completed tile.

Behaviour:
- Reset (rst=0, async; release is synchronous to clk):
  - acc, out_tile, k_cnt, tile_cnt, out_tile_idx are all 0.
  - out_valid=0; in_ready=1 once reset is released.
- Accept beat: in_valid && in_ready at a rising edge.
- k_cnt counts accepted chunks within the current tile, range 0..NUM_K_CHUNKS-1.
- Accumulate:
  - On an accept beat with k_cnt==0, acc[e] <= in_tile[e] (load, no read of stale acc).
  - Otherwise acc[e] <= acc[e] + in_tile[e].
  - Addition is modulo 2^WIDTH (unsigned wrap, no saturation, no overflow flag).
- Completing beat: an accept beat with k_cnt==NUM_K_CHUNKS-1. It causes:
  - out_tile[e] <= acc[e] + in_tile[e] (or in_tile[e] if NUM_K_CHUNKS==1);
  - out_tile_idx <= tile_cnt; out_valid <= 1;
  - k_cnt <= 0; tile_cnt <= tile_cnt+1, wrapping NUM_TILES-1 -> 0.
- Latency: out_valid rises the cycle after the completing beat's edge; one cycle from last chunk to result.
- Output handshake:
  - out_valid && out_ready at an edge pops the tile: out_valid <= 0, unless a completing beat happens at the same edge.
  - out_tile and out_tile_idx hold stable while out_valid && !out_ready.
- in_ready = !(k_cnt==NUM_K_CHUNKS-1 && out_valid && !out_ready).
  - Non-completing beats are never stalled.
  - A completing beat stalls only while the output buffer is full and not draining.
  - in_ready depends combinationally on out_ready; this path is permitted.
- Simultaneous completing beat and output pop: new tile overwrites out_tile, out_valid stays 1, no bubble.
- flush=1 at an edge:
  - k_cnt <= 0; the in-flight acc is discarded; any accept beat in that cycle is ignored; tile_cnt is unchanged.
  - The output buffer and its handshake are unaffected.
  - flush has priority over an accept beat.
- Reset mid-tile or mid-handshake: everything clears immediately (async); no partial tile is ever emitted.
- in_valid while in_ready=0: no state change. The upstream must hold its data.

Decomposition:
- Shared types package (already holds WIDTH, CHUNK_SIZE) gains:
  - typedef chunk_t, an unpacked array of CHUNK_SIZE**2 WIDTH-bit elements;
  - localparam CHUNK_ELEMS = CHUNK_SIZE**2.
- One natural sub-module: chunk_adder, a combinational element-wise modulo-2^WIDTH adder of two chunk_t with a load-select input.
- Counters and the output buffer stay in result_aggregator.

Test Plan:
Configuration for all scenarios: WIDTH=16, CHUNK_SIZE=2, NUM_K_CHUNKS=3, NUM_TILES=4.
- Basic sum: chunks {1,2,3,4},{10,20,30,40},{100,200,300,400} on consecutive cycles, out_ready=1 -> out_valid one cycle after the 3rd beat, out_tile={111,222,333,444}, out_tile_idx=0, valid for 1 cycle.
- Wrap: three chunks all {0x8000,0xFFFF,1,0} -> out_tile={0x8000,0xFFFD,3,0}.
- Backpressure: tile0 completes, out_ready=0; stream next tile {1,1,1,1} x3 -> in_ready=0 only on the 3rd chunk; out_tile stays tile0 values. Raise out_ready -> tile0 pops, 3rd chunk accepted at the same edge, out_tile={3,3,3,3}, idx=1, out_valid continuous.
- Flush: two chunks {5,5,5,5}, flush=1 with in_valid=1, then three chunks {1,2,3,4} -> out_tile={3,6,9,12}; idx unchanged by the flush.
- Index wrap: 5 complete tiles -> out_tile_idx sequence 0,1,2,3,0.
- Async reset: assert rst=0 mid-edge after 2 chunks with out_valid=1 -> out_valid=0 without a clock edge; after release, 3 new chunks produce a clean sum with idx=0.
